// File: rtl/red_pitaya_pll_seq.sv
// Housekeeping FF PLL sequencer: qualifies the reference, gates the phase
// detector enable, waits for lock, retries with back-off and latches a fault.
module red_pitaya_pll_seq #(
    parameter int REF_QUAL    = 3,
    parameter int SETTLE_CYC  = 12500000,
    parameter int LOSS_CYC    = 1250,
    parameter int BACKOFF_CYC = 1250000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             ctrl_en_i,
    input  logic             clr_i,
    input  logic             ref_val_i,
    input  logic             lck_i,
    output logic             pll_cfg_en_o,
    output logic             locked_o,
    output logic             fault_o,
    output logic [2:0]       state_o,
    output logic [3:0]       retry_cnt_o,
    output logic [CNT_W-1:0] loss_cnt_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_REF = 3'd1,
        SETTLE   = 3'd2,
        LOCKED   = 3'd3,
        BACKOFF  = 3'd4,
        FAULT    = 3'd5
    } state_t;

    // One timer serves both SETTLE and BACKOFF, sized for the longer window
    localparam int TMAX = (SETTLE_CYC > BACKOFF_CYC) ? SETTLE_CYC : BACKOFF_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int QW   = $clog2(REF_QUAL + 1);
    localparam int GW   = $clog2(LOSS_CYC + 1);

    localparam logic [TW-1:0]    SET_LAST  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]    BO_LAST   = TW'(BACKOFF_CYC - 1);
    localparam logic [QW-1:0]    QUAL_LAST = QW'(REF_QUAL - 1);
    localparam logic [GW-1:0]    LOSS_LAST = GW'(LOSS_CYC - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [CNT_W-1:0] LOSS_SAT  = '1;

    state_t           state, state_n;
    logic [QW-1:0]    qual, qual_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic [GW-1:0]    gl, gl_n;
    logic [3:0]       retry, retry_n;
    logic [CNT_W-1:0] loss, loss_n;
    logic             loss_inc;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            qual  <= '0;
            tmr   <= '0;
            gl    <= '0;
            retry <= '0;
            loss  <= '0;
        end else begin
            state <= state_n;
            qual  <= qual_n;
            tmr   <= tmr_n;
            gl    <= gl_n;
            retry <= retry_n;
            loss  <= loss_n;
        end
    end

    always_comb begin
        state_n  = state;
        qual_n   = qual;
        tmr_n    = tmr;
        gl_n     = gl;
        retry_n  = retry;
        loss_inc = 1'b0;
        if (state == FAULT && clr_i) begin
            state_n = IDLE;
            qual_n  = '0;
            tmr_n   = '0;
            gl_n    = '0;
            retry_n = '0;
        end else if (!ctrl_en_i && state != FAULT) begin
            state_n = IDLE;
            qual_n  = '0;
            tmr_n   = '0;
            gl_n    = '0;
            retry_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = WAIT_REF;
                    qual_n  = '0;
                end
                WAIT_REF: begin
                    if (!ref_val_i) begin
                        qual_n = '0;
                    end else if (qual == QUAL_LAST) begin
                        state_n = SETTLE;
                        qual_n  = '0;
                        tmr_n   = '0;
                    end else begin
                        qual_n = qual + 1'b1;
                    end
                end
                SETTLE: begin
                    // A reference drop outranks the lock decision
                    if (!ref_val_i) begin
                        state_n = WAIT_REF;
                        qual_n  = '0;
                        tmr_n   = '0;
                    end else if (tmr == SET_LAST) begin
                        tmr_n = '0;
                        if (lck_i) begin
                            state_n = LOCKED;
                            retry_n = '0;
                            gl_n    = '0;
                        end else if (retry == RETRY_MAX) begin
                            state_n = FAULT;
                        end else begin
                            state_n = BACKOFF;
                            retry_n = retry + 4'd1;
                        end
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!ref_val_i) begin
                        loss_inc = 1'b1;
                        state_n  = WAIT_REF;
                        qual_n   = '0;
                        gl_n     = '0;
                    end else if (lck_i) begin
                        gl_n = '0;
                    end else if (gl == LOSS_LAST) begin
                        loss_inc = 1'b1;
                        state_n  = BACKOFF;
                        tmr_n    = '0;
                        gl_n     = '0;
                    end else begin
                        gl_n = gl + 1'b1;
                    end
                end
                BACKOFF: begin
                    if (tmr == BO_LAST) begin
                        state_n = WAIT_REF;
                        qual_n  = '0;
                        tmr_n   = '0;
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                FAULT: begin
                    state_n = FAULT;
                end
                default: begin
                    state_n = IDLE;
                    qual_n  = '0;
                    tmr_n   = '0;
                    gl_n    = '0;
                    retry_n = '0;
                end
            endcase
        end
    end

    always_comb begin
        loss_n = loss;
        if (clr_i) begin
            loss_n = '0;
        end else if (loss_inc && loss != LOSS_SAT) begin
            loss_n = loss + 1'b1;
        end
    end

    assign pll_cfg_en_o = (state == SETTLE) || (state == LOCKED);
    assign locked_o     = (state == LOCKED);
    assign fault_o      = (state == FAULT);
    assign state_o      = state;
    assign retry_cnt_o  = retry;
    assign loss_cnt_o   = loss;

endmodule

// File: tb/tb_red_pitaya_pll_seq.sv
// Directed bench for red_pitaya_pll_seq: expected output snapshots are queued
// with a due cycle when stimulus is applied and compared when that cycle arrives.
module tb_red_pitaya_pll_seq;

    logic       clk;
    logic       rstn;
    logic       ctrl_en;
    logic       clr;
    logic       ref_val;
    logic       lck;
    logic       cfg_en;
    logic       locked;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry;
    logic [1:0] loss;

    red_pitaya_pll_seq #(
        .REF_QUAL   (3),
        .SETTLE_CYC (8),
        .LOSS_CYC   (4),
        .BACKOFF_CYC(5),
        .MAX_RETRY  (2),
        .CNT_W      (2)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .ctrl_en_i   (ctrl_en),
        .clr_i       (clr),
        .ref_val_i   (ref_val),
        .lck_i       (lck),
        .pll_cfg_en_o(cfg_en),
        .locked_o    (locked),
        .fault_o     (fault),
        .state_o     (state),
        .retry_cnt_o (retry),
        .loss_cnt_o  (loss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_SET  = 3'd2;
    localparam logic [2:0] S_LOCK = 3'd3;
    localparam logic [2:0] S_BO   = 3'd4;
    localparam logic [2:0] S_FLT  = 3'd5;

    typedef struct {
        int          due;
        logic [11:0] v;
    } sb_t;

    sb_t         sbq[$];
    string       tagq[$];
    int          cyc;
    int          checks;
    int          failures;
    int          exp_loss;
    logic [11:0] obs;

    assign obs = {state, cfg_en, locked, fault, retry, loss};

    function automatic logic [11:0] mk(logic [2:0] st, logic [3:0] rt,
                                       logic [1:0] ls);
        logic c, l, f;
        c = (st == S_SET) || (st == S_LOCK);
        l = (st == S_LOCK);
        f = (st == S_FLT);
        return {st, c, l, f, rt, ls};
    endfunction

    task automatic push(string tag, int off, logic [2:0] st, logic [3:0] rt,
                        int ls);
        sb_t e;
        e.due = cyc + off;
        e.v   = mk(st, rt, 2'(ls));
        sbq.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic drain();
        sb_t   e;
        string t;
        while (sbq.size() != 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            t = tagq.pop_front();
            checks++;
            if (e.due != cyc) begin
                failures++;
                $error("FAIL %s late: due=%0d now=%0d", t, e.due, cyc);
            end else begin
                assert (obs === e.v) else begin
                    failures++;
                    $error("FAIL %s observed=%h expected=%h", t, obs, e.v);
                end
            end
        end
    endtask

    task automatic steps(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            drain();
        end
    endtask

    task automatic relock(string tag);
        ref_val = 1'b1;
        lck     = 1'b1;
        push({tag, "_settle"}, 3, S_SET, 0, exp_loss);
        push({tag, "_locked"}, 11, S_LOCK, 0, exp_loss);
        steps(11);
    endtask

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        exp_loss = 0;
        rstn     = 1'b0;
        ctrl_en  = 1'b0;
        clr      = 1'b0;
        ref_val  = 1'b0;
        lck      = 1'b0;

        push("reset", 1, S_IDLE, 0, 0);
        steps(2);
        rstn = 1'b1;
        push("idle_off", 1, S_IDLE, 0, 0);
        steps(1);

        ctrl_en = 1'b1;
        ref_val = 1'b1;
        lck     = 1'b1;
        push("t1_wait", 1, S_WAIT, 0, 0);
        push("t1_wait3", 3, S_WAIT, 0, 0);
        push("t1_settle", 4, S_SET, 0, 0);
        push("t1_settle_end", 11, S_SET, 0, 0);
        push("t1_locked", 12, S_LOCK, 0, 0);
        steps(12);

        ctrl_en = 1'b0;
        push("t2_idle", 1, S_IDLE, 0, 0);
        steps(1);
        ctrl_en = 1'b1;
        lck     = 1'b0;
        push("t2_wait", 1, S_WAIT, 0, 0);
        push("t2_settle1", 4, S_SET, 0, 0);
        push("t2_settle1_end", 11, S_SET, 0, 0);
        push("t2_bo1", 12, S_BO, 1, 0);
        push("t2_bo1_end", 16, S_BO, 1, 0);
        push("t2_wait2", 17, S_WAIT, 1, 0);
        push("t2_settle2", 20, S_SET, 1, 0);
        push("t2_bo2", 28, S_BO, 2, 0);
        push("t2_wait3", 33, S_WAIT, 2, 0);
        push("t2_settle3", 36, S_SET, 2, 0);
        push("t2_settle3_end", 43, S_SET, 2, 0);
        push("t2_fault", 44, S_FLT, 2, 0);
        steps(44);
        ctrl_en = 1'b0;
        push("t2_fault_en0a", 1, S_FLT, 2, 0);
        push("t2_fault_en0b", 2, S_FLT, 2, 0);
        steps(2);
        ctrl_en = 1'b1;
        push("t2_fault_en1", 1, S_FLT, 2, 0);
        steps(1);
        clr = 1'b1;
        push("t2_clr_idle", 1, S_IDLE, 0, 0);
        steps(1);
        clr = 1'b0;

        lck = 1'b1;
        push("t3_wait", 1, S_WAIT, 0, 0);
        push("t3_settle", 4, S_SET, 0, 0);
        push("t3_locked", 12, S_LOCK, 0, 0);
        steps(12);
        lck = 1'b0;
        push("t3_glitch3", 3, S_LOCK, 0, 0);
        steps(3);
        lck = 1'b1;
        push("t3_glitch_end", 1, S_LOCK, 0, 0);
        steps(1);
        lck = 1'b0;
        push("t3_loss_pre", 3, S_LOCK, 0, 0);
        push("t3_loss_bo", 4, S_BO, 0, 1);
        push("t3_bo_mid", 6, S_BO, 0, 1);
        push("t3_bo_end", 8, S_BO, 0, 1);
        push("t3_wait", 9, S_WAIT, 0, 1);
        push("t4_settle", 12, S_SET, 0, 1);
        push("t4_settle_end", 19, S_SET, 0, 1);
        steps(19);

        ref_val = 1'b0;
        push("t4_refdrop", 1, S_WAIT, 0, 1);
        steps(1);
        ref_val = 1'b1;
        push("t4_settle2", 3, S_SET, 0, 1);
        push("t4_bo", 11, S_BO, 1, 1);
        steps(11);
        ctrl_en = 1'b0;
        push("t4_bo_idle", 1, S_IDLE, 0, 1);
        steps(1);

        clr = 1'b1;
        push("t5_clr_idle", 1, S_IDLE, 0, 0);
        steps(1);
        clr      = 1'b0;
        ctrl_en  = 1'b1;
        ref_val  = 1'b0;
        exp_loss = 0;
        push("t5_wait", 1, S_WAIT, 0, 0);
        steps(1);
        for (int i = 0; i < 5; i++) begin
            relock("t5");
            ref_val  = 1'b0;
            exp_loss = (exp_loss == 3) ? 3 : exp_loss + 1;
            push("t5_loss", 1, S_WAIT, 0, exp_loss);
            steps(1);
        end
        relock("t5_6th");
        ref_val  = 1'b0;
        clr      = 1'b1;
        exp_loss = 0;
        push("t5_clr_wins", 1, S_WAIT, 0, 0);
        steps(1);
        clr = 1'b0;

        relock("t6");
        ref_val  = 1'b0;
        exp_loss = 1;
        push("t6_loss", 1, S_WAIT, 0, 1);
        steps(1);
        ref_val = 1'b1;
        lck     = 1'b0;
        push("t6_settle", 3, S_SET, 0, 1);
        steps(5);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        assert (obs === mk(S_IDLE, 0, 0)) else begin
            failures++;
            $error("FAIL t6_async_rst observed=%h expected=%h", obs,
                   mk(S_IDLE, 0, 0));
        end
        push("t6_in_reset", 1, S_IDLE, 0, 0);
        steps(1);
        rstn = 1'b1;
        push("t6_release", 1, S_WAIT, 0, 0);
        steps(1);

        steps(2);
        checks++;
        assert (sbq.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
